flight_sequencer: RTL
=====================

# flight_sequencer

Control-loop scheduler and arming supervisor for the drone2 flight pipeline. Each IMU `valid_strobe` starts one pass through the control stages in a fixed order: yaw angle accumulator, then angle controller, then body frame controller. The block issues one start pulse per stage and waits for that stage's complete pulse before moving on. It applies a per-stage watchdog, counts IMU sample overruns, and runs the arm/disarm state machine that gates `motors_enable` to the PWM generator.

## Interface
Parameters:
- `STAGES`, 3, number of chained stages; bit k is stage k in execution order.
- `TIMEOUT_US`, 2000, maximum cycles a stage may stay busy after its start pulse.
- `ARM_HOLD_US`, 500000, cycles the arm condition must hold before entering ARMED.
- `THROTTLE_ARM_MAX`, 8'd10, highest throttle value allowed for arming.

Ports:
- `us_clk`  in  1  1 MHz clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `imu_good`  in  1  IMU driver healthy.
- `imu_valid_strobe`  in  1  one-cycle pulse when a new IMU sample is ready.
- `stage_complete`  in  STAGES  per-stage one-cycle complete pulses.
- `throttle_val`  in  `REC_VAL_BIT_WIDTH`  receiver throttle value, 0-255.
- `swa_swb_val`  in  `REC_VAL_BIT_WIDTH`  arm switch; value >= 128 means arm requested.
- `stage_start`  out  STAGES  one-hot, one-cycle start pulse.
- `cycle_done`  out  1  one-cycle pulse after the last stage completes.
- `motors_enable`  out  1  high only in ARMED.
- `fault`  out  1  high only in FAULT.
- `fault_code`  out  2  00 none, 01 stage timeout, 10 IMU lost.
- `overrun_count`  out  8  saturating count of dropped IMU strobes.
- `seq_state`  out  3  {arm state[1:0], sequencer busy} for debug LEDs.

## Operation
Sequencer FSM has two states, WAIT and RUN, plus stage index `k`:
- WAIT with `imu_valid_strobe` = 1 → RUN with k = 0. `stage_start[0]` pulses.
- RUN, `stage_complete[k]` = 1, k < STAGES-1 → k = k+1. `stage_start[k+1]` pulses.
- RUN, `stage_complete[STAGES-1]` = 1 → WAIT. `cycle_done` pulses.
- `stage_complete` bits other than bit k are ignored.
- `imu_valid_strobe` outside WAIT, including the same cycle as the final complete, is dropped. `overrun_count` increments and holds at 255.
- The watchdog counter clears on every `stage_start`. If it reaches TIMEOUT_US in RUN → WAIT with no `cycle_done`, and the arm FSM takes a timeout fault.
- The sequencer runs whether or not the system is armed, so the loop output is valid before arming.

Arm FSM has four states: DISARMED, ARMING, ARMED, FAULT.
- The arm condition is: switch >= 128, throttle <= THROTTLE_ARM_MAX, `imu_good` = 1.
- DISARMED → ARMING when the arm condition holds. The hold counter clears on entry.
- ARMING → DISARMED as soon as the arm condition drops.
- ARMING → ARMED when the hold counter reaches ARM_HOLD_US.
- ARMED → DISARMED when the switch drops below 128. Throttle is free while ARMED.
- ARMED or ARMING → FAULT on `imu_good` = 0 (code 10) or a watchdog timeout (code 01).
- If both fault causes occur in the same cycle, code 10 wins.
- FAULT → DISARMED only when the switch is < 128 and throttle <= THROTTLE_ARM_MAX. `fault_code` clears on that exit.

## Timing
- All outputs are registered.
- Reset values: `stage_start` = 0, `cycle_done` = 0, `motors_enable` = 0, `fault` = 0, `fault_code` = 00, `overrun_count` = 0. FSMs reset to WAIT and DISARMED, counters to 0.
- Strobe at cycle t → `stage_start[0]` high at t+1.
- `stage_complete[k]` at t → `stage_start[k+1]` (or `cycle_done`) at t+1.
- Timeout: start pulse at t with no complete → fault visible at t+TIMEOUT_US+1.
- A complete pulse arriving in the same cycle as the timeout is honoured; no fault is raised.
- Arming: condition true from t → `motors_enable` high at t+ARM_HOLD_US+1.
- Disarm or fault clears `motors_enable` on the next cycle.
- `reset` asserted mid-run aborts the sequence. No pulses are emitted in the cycle after reset.

## Configuration
- `FLIGHT_SEQ_WATCHDOG_EN` defined: watchdog counter present and timeout fault behaves as described above.
- Not defined: no watchdog counter. RUN waits indefinitely for completes, and `fault_code` 01 is never produced. IMU-lost fault is unaffected.

## Structure
- Add to `common_defines.v`:
  - arm state encodings (DISARMED 00, ARMING 01, ARMED 10, FAULT 11);
  - fault code constants;
  - `FLIGHT_SEQ_WATCHDOG_EN`;
  - reuse of `REC_VAL_BIT_WIDTH`.
- One sub-module, `arm_controller`: the arm FSM and hold counter. It takes the sequencer's timeout pulse as an input. The sequencer and watchdog stay in the top of the block.

## Test plan
- IMU strobe, each stage completing 5 cycles after its start → starts at t+1, t+7, t+13; `cycle_done` at t+19.
- Second strobe while in RUN k=1 → strobe ignored, `overrun_count` = 1. 300 such strobes → count holds at 255.
- Switch = 200, throttle = 5, `imu_good` = 1, ARM_HOLD_US = 100 → `motors_enable` high exactly 101 cycles later. Throttle raised to 50 at hold cycle 60 → returns to DISARMED, no enable.
- Armed, stage 1 never completes, TIMEOUT_US = 20 → `fault` = 1, code 01, `motors_enable` = 0. Switch = 0 with throttle 5 → DISARMED, code 00.
- Armed, `imu_good` dropped in the same cycle as a timeout → code 10.
- `reset` during RUN k=2 → all outputs at reset values next cycle. A fresh strobe restarts the sequence at stage 0.

Source files
------------

// File: rtl/flight_sequencer_pkg.sv
// Shared types and constants for the flight sequencer and its arm controller.
// The optional stage watchdog is enabled by defining FLIGHT_SEQ_WATCHDOG_EN.
package flight_sequencer_pkg;

  localparam int unsigned REC_VAL_BIT_WIDTH = 8;

  typedef enum logic [1:0] {
    ARM_DISARMED = 2'b00,
    ARM_ARMING   = 2'b01,
    ARM_ARMED    = 2'b10,
    ARM_FAULT    = 2'b11
  } arm_state_t;

  typedef enum logic {
    SEQ_WAIT = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
  localparam logic [1:0] FAULT_IMU_LOST = 2'b10;

  // Receiver values are 0-255, so ">= 128" is simply the top bit.
  function automatic logic arm_switch_on(input logic [REC_VAL_BIT_WIDTH-1:0] val);
    return val[REC_VAL_BIT_WIDTH-1];
  endfunction

endpackage

// File: rtl/flight_sequencer_arm_controller.sv
// Arm/disarm supervisor: hold counter, fault capture and motors_enable gating.
module arm_controller
  import flight_sequencer_pkg::*;
#(
  parameter int unsigned                   ARM_HOLD_US      = 500000,
  parameter logic [REC_VAL_BIT_WIDTH-1:0]  THROTTLE_ARM_MAX = 8'd10
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_imu_good,
  input  logic                         i_timeout,
  input  logic [REC_VAL_BIT_WIDTH-1:0] i_throttle_val,
  input  logic [REC_VAL_BIT_WIDTH-1:0] i_swa_swb_val,
  output logic                         o_motors_enable,
  output logic                         o_fault,
  output logic [1:0]                   o_fault_code,
  output arm_state_t                   o_arm_state
);

  localparam int unsigned HOLD_W = $clog2(ARM_HOLD_US + 1);

  arm_state_t        r_state;
  logic [HOLD_W-1:0] r_hold;
  logic              r_motors;
  logic              r_fault;
  logic [1:0]        r_code;

  logic w_sw_on;
  logic w_thr_low;
  logic w_arm_cond;

  assign w_sw_on    = arm_switch_on(i_swa_swb_val);
  assign w_thr_low  = (i_throttle_val <= THROTTLE_ARM_MAX);
  assign w_arm_cond = w_sw_on && w_thr_low && i_imu_good;

  // The hold count includes the DISARMED->ARMING cycle, so ARMED is entered
  // ARM_HOLD_US cycles after the condition first appears.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ARM_DISARMED;
      r_hold   <= '0;
      r_motors <= 1'b0;
      r_fault  <= 1'b0;
      r_code   <= FAULT_NONE;
    end else begin
      case (r_state)
        ARM_DISARMED: begin
          if (w_arm_cond) begin
            r_state <= ARM_ARMING;
            r_hold  <= '0;
          end
        end
        ARM_ARMING, ARM_ARMED: begin
          if (!i_imu_good || i_timeout) begin
            r_state  <= ARM_FAULT;
            r_motors <= 1'b0;
            r_fault  <= 1'b1;
            r_code   <= !i_imu_good ? FAULT_IMU_LOST : FAULT_TIMEOUT;
          end else if (r_state == ARM_ARMED) begin
            if (!w_sw_on) begin
              r_state  <= ARM_DISARMED;
              r_motors <= 1'b0;
            end
          end else if (!w_arm_cond) begin
            r_state <= ARM_DISARMED;
          end else if (r_hold == HOLD_W'(ARM_HOLD_US - 1)) begin
            r_state  <= ARM_ARMED;
            r_motors <= 1'b1;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        ARM_FAULT: begin
          if (!w_sw_on && w_thr_low) begin
            r_state <= ARM_DISARMED;
            r_fault <= 1'b0;
            r_code  <= FAULT_NONE;
          end
        end
        default: r_state <= ARM_DISARMED;
      endcase
    end
  end

  assign o_motors_enable = r_motors;
  assign o_fault         = r_fault;
  assign o_fault_code    = r_code;
  assign o_arm_state     = r_state;

endmodule

// File: rtl/flight_sequencer.sv
// Control-loop stage scheduler with IMU overrun counting and arm supervision.
// Define FLIGHT_SEQ_WATCHDOG_EN to include the per-stage watchdog.
module flight_sequencer
  import flight_sequencer_pkg::*;
#(
  parameter int unsigned                   STAGES           = 3,
  parameter int unsigned                   TIMEOUT_US       = 2000,
  parameter int unsigned                   ARM_HOLD_US      = 500000,
  parameter logic [REC_VAL_BIT_WIDTH-1:0]  THROTTLE_ARM_MAX = 8'd10
) (
  input  logic                         us_clk,
  input  logic                         reset,
  input  logic                         imu_good,
  input  logic                         imu_valid_strobe,
  input  logic [STAGES-1:0]            stage_complete,
  input  logic [REC_VAL_BIT_WIDTH-1:0] throttle_val,
  input  logic [REC_VAL_BIT_WIDTH-1:0] swa_swb_val,
  output logic [STAGES-1:0]            stage_start,
  output logic                         cycle_done,
  output logic                         motors_enable,
  output logic                         fault,
  output logic [1:0]                   fault_code,
  output logic [7:0]                   overrun_count,
  output logic [2:0]                   seq_state
);

  localparam int unsigned K_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  seq_state_t        r_seq;
  logic [K_W-1:0]    r_k;
  logic [STAGES-1:0] r_start;
  logic              r_done;
  logic [7:0]        r_ovr;

  logic       w_stage_cpl;
  logic       w_last;
  logic       w_issue;
  logic       w_timeout;
  arm_state_t w_arm_state;

  assign w_stage_cpl = stage_complete[r_k];
  assign w_last      = (r_k == K_W'(STAGES - 1));
  assign w_issue     = ((r_seq == SEQ_WAIT) && imu_valid_strobe) ||
                       ((r_seq == SEQ_RUN) && w_stage_cpl && !w_last);

`ifdef FLIGHT_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_US + 1);
  logic [WD_W-1:0] r_wdog;

  // Cleared on the edge that issues a start, so it reads 0 during the pulse.
  always_ff @(posedge us_clk) begin
    if (reset || w_issue) begin
      r_wdog <= '0;
    end else if (r_seq == SEQ_RUN && r_wdog != WD_W'(TIMEOUT_US)) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_timeout = (r_seq == SEQ_RUN) && !w_stage_cpl && (r_wdog == WD_W'(TIMEOUT_US));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge us_clk) begin
    if (reset) begin
      r_seq   <= SEQ_WAIT;
      r_k     <= '0;
      r_start <= '0;
      r_done  <= 1'b0;
      r_ovr   <= '0;
    end else begin
      r_start <= '0;
      r_done  <= 1'b0;
      if (imu_valid_strobe && r_seq != SEQ_WAIT && r_ovr != 8'hFF) begin
        r_ovr <= r_ovr + 8'd1;
      end
      case (r_seq)
        SEQ_WAIT: begin
          if (imu_valid_strobe) begin
            r_seq   <= SEQ_RUN;
            r_k     <= '0;
            r_start <= STAGES'(1);
          end
        end
        SEQ_RUN: begin
          if (w_stage_cpl) begin
            if (w_last) begin
              r_seq  <= SEQ_WAIT;
              r_done <= 1'b1;
            end else begin
              r_k     <= r_k + 1'b1;
              r_start <= STAGES'(2) << r_k;
            end
          end else if (w_timeout) begin
            r_seq <= SEQ_WAIT;
          end
        end
        default: r_seq <= SEQ_WAIT;
      endcase
    end
  end

  arm_controller #(
    .ARM_HOLD_US      (ARM_HOLD_US),
    .THROTTLE_ARM_MAX (THROTTLE_ARM_MAX)
  ) u_arm (
    .i_clk           (us_clk),
    .i_reset         (reset),
    .i_imu_good      (imu_good),
    .i_timeout       (w_timeout),
    .i_throttle_val  (throttle_val),
    .i_swa_swb_val   (swa_swb_val),
    .o_motors_enable (motors_enable),
    .o_fault         (fault),
    .o_fault_code    (fault_code),
    .o_arm_state     (w_arm_state)
  );

  assign stage_start   = r_start;
  assign cycle_done    = r_done;
  assign overrun_count = r_ovr;
  assign seq_state     = {w_arm_state, r_seq == SEQ_RUN};

endmodule
